// File: rtl/mcp_pkg.sv
// Shared definitions for the multicycle-path register launcher: FSM encoding,
// reset pattern of the launched value, and counter sizing.
`ifndef BSV_ASSIGNMENT_DELAY
`define BSV_ASSIGNMENT_DELAY
`endif

package mcp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        FIRE   = 2'd2
    } mcp_state_e;

    localparam int MCP_MAX_WIDTH = 1024;

    // Repeated 2'b10 pattern from the LSB up, cleared above the requested width.
    function automatic logic [MCP_MAX_WIDTH-1:0] mcp_reset_pattern(input int width);
        logic [MCP_MAX_WIDTH-1:0] pat;
        pat = {MCP_MAX_WIDTH{1'b0}};
        for (int i = 0; i < MCP_MAX_WIDTH; i++) begin
            if ((i < width) && (i[0] == 1'b1)) begin
                pat[i] = 1'b1;
            end else begin
                pat[i] = 1'b0;
            end
        end
        return pat;
    endfunction

    function automatic int mcp_cnt_width(input int delay);
        if (delay <= 1) begin
            return 1;
        end else begin
            return $clog2(delay + 1);
        end
    endfunction

endpackage

// File: rtl/mcp_reg_launch_chk.sv
// Protocol checker for the launcher outputs; simulation-only assertions.
module mcp_reg_launch_chk (
    input logic CLK,
    input logic RST,
    input logic RDY_put,
    input logic mcp_set
);

    ap_set_single: assert property (@(posedge CLK) disable iff (RST) mcp_set |=> !mcp_set);
    ap_set_not_rdy: assert property (@(posedge CLK) disable iff (RST) !(mcp_set && RDY_put));
    ap_set_then_rdy: assert property (@(posedge CLK) disable iff (RST) mcp_set |=> RDY_put);

endmodule

// File: rtl/mcp_settle_counter.sv
// Settle down-counter: loads the remaining settle cycles on launch and
// counts down to a zero flag without wrapping.
`ifndef BSV_ASSIGNMENT_DELAY
`define BSV_ASSIGNMENT_DELAY
`endif

module mcp_settle_counter #(
    parameter int CNT_W = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] count_r;

    // Count register: reset clears, load wins over decrement, zero holds.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_r <= `BSV_ASSIGNMENT_DELAY CNT_ZERO;
        end else if (load) begin
            count_r <= `BSV_ASSIGNMENT_DELAY load_val;
        end else if (dec && (count_r != CNT_ZERO)) begin
            count_r <= `BSV_ASSIGNMENT_DELAY count_r - CNT_ONE;
        end else begin
            count_r <= `BSV_ASSIGNMENT_DELAY count_r;
        end
    end

    assign zero = (count_r == CNT_ZERO);

endmodule

// File: rtl/mcp_reg_launch.sv
// Launches a value into a destination multicycle capture register: the value is
// registered on acceptance and the capture strobe follows after the settle delay.
`ifndef BSV_ASSIGNMENT_DELAY
`define BSV_ASSIGNMENT_DELAY
`endif

module mcp_reg_launch
    import mcp_pkg::*;
#(
    parameter int width = 1,
    parameter int delay = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN_put,
    input  logic [width-1:0] put_val,
    output logic             RDY_put,
    output logic [width-1:0] mcp_val,
    output logic             mcp_set,
    output logic             put_drop
);

    localparam int                       CNT_W        = mcp_cnt_width(delay);
    localparam logic [MCP_MAX_WIDTH-1:0] RST_PAT_FULL = mcp_reset_pattern(width);
    localparam logic [width-1:0]         RST_PAT      = RST_PAT_FULL[width-1:0];
    localparam logic [CNT_W-1:0]         LOAD_VAL     = CNT_W'((delay > 0) ? (delay - 1) : 0);
    // A zero settle delay skips SETTLE entirely.
    localparam mcp_state_e               LAUNCH_ST    = (delay == 0) ? FIRE : SETTLE;

    mcp_state_e       state_r;
    mcp_state_e       state_nxt_s;
    logic             accept_s;
    logic             dec_s;
    logic             drop_s;
    logic             cnt_zero_s;
    logic             rdy_r;
    logic             set_r;
    logic             drop_r;
    logic [width-1:0] val_r;

    mcp_settle_counter #(
        .CNT_W(CNT_W)
    ) u_settle_counter (
        .CLK      (CLK),
        .RST      (RST),
        .load     (accept_s),
        .load_val (LOAD_VAL),
        .dec      (dec_s),
        .zero     (cnt_zero_s)
    );

    // Next-state decode plus accept, decrement and drop qualifiers.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        dec_s       = 1'b0;
        drop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (EN_put) begin
                    accept_s    = 1'b1;
                    state_nxt_s = LAUNCH_ST;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETTLE: begin
                if (cnt_zero_s) begin
                    state_nxt_s = FIRE;
                end else begin
                    dec_s       = 1'b1;
                    state_nxt_s = SETTLE;
                end
            end
            FIRE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        if (EN_put && (state_r != IDLE)) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end
    end

    // State register and registered outputs; outputs are pre-decoded from next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= `BSV_ASSIGNMENT_DELAY IDLE;
            rdy_r   <= `BSV_ASSIGNMENT_DELAY 1'b1;
            set_r   <= `BSV_ASSIGNMENT_DELAY 1'b0;
            drop_r  <= `BSV_ASSIGNMENT_DELAY 1'b0;
            val_r   <= `BSV_ASSIGNMENT_DELAY RST_PAT;
        end else begin
            state_r <= `BSV_ASSIGNMENT_DELAY state_nxt_s;
            rdy_r   <= `BSV_ASSIGNMENT_DELAY (state_nxt_s == IDLE);
            set_r   <= `BSV_ASSIGNMENT_DELAY (state_nxt_s == FIRE);
            drop_r  <= `BSV_ASSIGNMENT_DELAY drop_s;
            if (accept_s) begin
                val_r <= `BSV_ASSIGNMENT_DELAY put_val;
            end else begin
                val_r <= `BSV_ASSIGNMENT_DELAY val_r;
            end
        end
    end

    assign RDY_put  = rdy_r;
    assign mcp_val  = val_r;
    assign mcp_set  = set_r;
    assign put_drop = drop_r;

endmodule
